hilo_muldiv_unit: RTL and testbench

//  Iterative multiply/divide execute unit in EX, beside the ALU. Consumes the 3-bit MD control

---
 rtl/md_pkg.sv | 21 ++
 rtl/md_sign_fix.sv | 29 ++
 rtl/hilo_muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// The control decoder imports the same MD op codes.
package md_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate of the FIX-stage result: the full
// 2W product for multiply, or the remainder/quotient halves independently for divide.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] val_i,
  input  logic               split_i,
  input  logic               neg_hi_i,
  input  logic               neg_lo_i,
  output logic [2*WIDTH-1:0] val_o
);

  logic [WIDTH-1:0] hi_in;
  logic [WIDTH-1:0] lo_in;

  assign hi_in = val_i[2*WIDTH-1:WIDTH];
  assign lo_in = val_i[WIDTH-1:0];

  always_comb begin
    val_o = val_i;
    if (split_i) begin
      val_o[2*WIDTH-1:WIDTH] = neg_hi_i ? (~hi_in + 1'b1) : hi_in;
      val_o[WIDTH-1:0]       = neg_lo_i ? (~lo_in + 1'b1) : lo_in;
    end else if (neg_lo_i) begin
      val_o = ~val_i + 1'b1;
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Radix-2 iterative multiply/divide unit owning HI/LO; one result bit per cycle.
// Optional MD_EARLY_OUT_EN: multiply finishes once the remaining multiplier bits are zero.
module hilo_muldiv_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             md_valid,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic               is_div_q, is_div_d;
  logic               sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               op_signed, op_div, op_arith;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     rem_sh, rem_diff;
  logic [2*WIDTH-1:0] fix_val;

  assign op_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
  assign op_div    = (md_op == MD_DIV)  || (md_op == MD_DIVU);
  assign op_arith  = (md_op == MD_MULT) || (md_op == MD_MULTU) || op_div;
  assign a_mag     = (op_signed && src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
  assign b_mag     = (op_signed && src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;

  // Restoring divide: acc holds {remainder, dividend/quotient}, mplr holds divisor
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, mplr_q};

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .val_i    (acc_q),
    .split_i  (is_div_q),
    .neg_hi_i (is_div_q ? sa_q : (sa_q ^ sb_q)),
    .neg_lo_i ((sa_q ^ sb_q) & ~(is_div_q & bz_q)),
    .val_o    (fix_val)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    bz_d     = bz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (md_valid && !flush) begin
          if (op_arith) begin
            is_div_d = op_div;
            sa_d     = op_signed & src_a[WIDTH-1];
            sb_d     = op_signed & src_b[WIDTH-1];
            bz_d     = (src_b == '0);
            cnt_d    = '0;
            mplr_d   = b_mag;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            acc_d    = op_div ? {{WIDTH{1'b0}}, a_mag} : '0;
            state_d  = ST_CALC;
`ifdef MD_EARLY_OUT_EN
            if (!op_div && b_mag == '0) state_d = ST_FIX;
`endif
          end else if (md_op == MD_MTHI) begin
            hi_d = src_a;
          end else if (md_op == MD_MTLO) begin
            lo_d = src_a;
          end
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          if (is_div_q) begin
            if (!rem_diff[WIDTH]) acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else                  acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            if (mplr_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplr_d  = {1'b0, mplr_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
`ifdef MD_EARLY_OUT_EN
          if (!is_div_q && mplr_q[WIDTH-1:1] == '0) state_d = ST_FIX;
`endif
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          hi_d   = fix_val[2*WIDTH-1:WIDTH];
          lo_d   = fix_val[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      bz_q     <= bz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed + randomized bench for hilo_muldiv_unit against an arithmetic reference model.
// Latency expectations follow MD_EARLY_OUT_EN when it is defined.
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         md_valid;
  logic [2:0]   md_op;
  logic [W-1:0] src_a, src_b;
  logic         flush;
  logic         busy_o, done_o;
  logic [W-1:0] hi_o, lo_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_hi, exp_lo;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .md_valid(md_valid), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    case (op)
      3'd1: res = 64'(sa * sb);
      3'd2: res = ua * ub;
      3'd3: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd4: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {32'(ua % ub), 32'(ua / ub)};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic int exp_busy(input logic [2:0] op, input logic [W-1:0] b);
    int n;
    logic [W-1:0] mag;
    n = W + 1;
`ifdef MD_EARLY_OUT_EN
    if (op == 3'd1 || op == 3'd2) begin
      mag = (op == 3'd1 && b[W-1]) ? -b : b;
      n = 1;
      while (mag != 0) begin
        mag = mag >> 1;
        n++;
      end
    end
`else
    mag = b;
    if (op == 3'd0) n = int'(mag[0]);
`endif
    return n;
  endfunction

  task automatic run_md(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc;
    logic [63:0] r;
    r = model(op, a, b);
    @(negedge clk);
    md_valid = 1'b1; md_op = op; src_a = a; src_b = b;
    @(negedge clk);
    md_valid = 1'b0;
    cyc = 0;
    while (busy_o && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy"}, 64'(cyc), 64'(exp_busy(op, b)));
    check({tag, "_done"}, 64'(done_o), 64'd1);
    check({tag, "_hi"}, 64'(hi_o), 64'(r[63:32]));
    check({tag, "_lo"}, 64'(lo_o), 64'(r[31:0]));
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    @(negedge clk);
    check({tag, "_done_clr"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    logic [2:0] rop;
    logic [W-1:0] ra, rb;
    rst = 1'b1; md_valid = 1'b0; md_op = 3'd0; src_a = '0; src_b = '0; flush = 1'b0;
    exp_hi = '0; exp_lo = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_hi", 64'(hi_o), 64'd0);
    check("rst_lo", 64'(lo_o), 64'd0);
    rst = 1'b0;

    run_md("mult_neg3x5", 3'd1, -32'sd3, 32'd5);
    check("mult_lit_hi", 64'(exp_hi), 64'hFFFF_FFFF);
    check("mult_lit_lo", 64'(exp_lo), 64'hFFFF_FFF1);
    run_md("divu_100_7", 3'd4, 32'd100, 32'd7);
    check("divu_lit", {32'(exp_hi), 32'(exp_lo)}, {32'd2, 32'd14});
    run_md("div_neg7_2", 3'd3, -32'sd7, 32'd2);
    check("div_lit", {32'(exp_hi), 32'(exp_lo)}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_md("divu_by0", 3'd4, 32'd5, 32'd0);
    run_md("div_by0_neg", 3'd3, -32'sd9, 32'd0);
    run_md("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lit", {32'(exp_hi), 32'(exp_lo)}, {32'd0, 32'h8000_0000});
    run_md("mult_neg_neg", 3'd1, 32'hFFFF_FFFF, 32'h8000_0000);
    run_md("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef MD_EARLY_OUT_EN
    run_md("multu_3x1", 3'd2, 32'd3, 32'd1);
    run_md("mult_x0", 3'd1, 32'd77, 32'd0);
`endif

    // Flush MULTU mid-run: busy drops next edge, HI/LO kept, no done
    @(negedge clk);
    md_valid = 1'b1; md_op = 3'd2; src_a = 32'd7; src_b = 32'd9;
    @(negedge clk);
    md_valid = 1'b0;
    repeat (1) @(negedge clk);
    check("flush_busy_before", 64'(busy_o), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy_o), 64'd0);
    check("flush_done", 64'(done_o), 64'd0);
    @(negedge clk);
    check("flush_done2", 64'(done_o), 64'd0);
    check("flush_hilo", {32'(hi_o), 32'(lo_o)}, {32'(exp_hi), 32'(exp_lo)});

    // Flush on the FIX cycle wins over the write
    @(negedge clk);
    md_valid = 1'b1; md_op = 3'd4; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);
    md_valid = 1'b0;
    repeat (W) @(negedge clk);
    check("fixflush_busy", 64'(busy_o), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fixflush_busy2", 64'(busy_o), 64'd0);
    check("fixflush_done", 64'(done_o), 64'd0);
    check("fixflush_hilo", {32'(hi_o), 32'(lo_o)}, {32'(exp_hi), 32'(exp_lo)});

    // MTHI/MTLO in IDLE, and flush suppressing an MT write
    @(negedge clk);
    md_valid = 1'b1; md_op = 3'd5; src_a = 32'h1234;
    @(negedge clk);
    md_op = 3'd6; src_a = 32'hABCD_0001;
    check("mthi_hi", 64'(hi_o), 64'h1234);
    check("mthi_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    md_valid = 1'b0;
    check("mtlo_lo", 64'(lo_o), 64'hABCD_0001);
    check("mt_done", 64'(done_o), 64'd0);
    exp_hi = 32'h1234; exp_lo = 32'hABCD_0001;
    md_valid = 1'b1; md_op = 3'd5; src_a = 32'hDEAD_0000; flush = 1'b1;
    @(negedge clk);
    md_valid = 1'b0; flush = 1'b0;
    check("mt_flush_hi", 64'(hi_o), 64'(exp_hi));

    // MTHI while busy is ignored; DIVU result lands normally
    @(negedge clk);
    md_valid = 1'b1; md_op = 3'd4; src_a = 32'd50; src_b = 32'd8;
    @(negedge clk);
    md_op = 3'd5; src_a = 32'hBAD0_BAD0;
    repeat (3) @(negedge clk);
    md_valid = 1'b0;
    check("mthi_busy_hi", 64'(hi_o), 64'(exp_hi));
    repeat (W + 2) @(negedge clk);
    check("mthi_busy_res", {32'(hi_o), 32'(lo_o)}, {32'd2, 32'd6});
    check("mthi_busy_idle", 64'(busy_o), 64'd0);
    exp_hi = 32'd2; exp_lo = 32'd6;

    // Randomized MULT/DIV against the model
    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = '0;
      else if (i % 3 == 0) rb = rb >> $urandom_range(0, 31);
      run_md("rand", rop, ra, rb);
    end

    // Asynchronous reset mid-DIV
    @(negedge clk);
    md_valid = 1'b1; md_op = 3'd3; src_a = 32'd12345; src_b = 32'd17;
    @(negedge clk);
    md_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_hilo", {32'(hi_o), 32'(lo_o)}, 64'd0);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_done", 64'(done_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
